ycbcr_conv_arbiter: RTL

YCBCR_CONV_ARBITER -- requirements
Module: ycbcr_conv_arbiter

---
 rtl/ycbcr_conv_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/ycbcr_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ycbcr_conv_arbiter
// Description : Shares one RGB-to-YCbCr converter between a palette loader
//               (port A) and a live pixel stream (port B). B has priority,
//               and A is forced a slot after a bounded stall. Converter
//               results are routed back to their source with A's tag.
// Revision    : 1.0 - initial release
// ============================================================================
module ycbcr_conv_arbiter #(
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [23:0] a_rgb,
    input  logic [7:0]  a_tag,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [23:0] b_rgb,
    output logic        b_ready,
    output logic [23:0] conv_rgb,
    input  logic [23:0] conv_ycbcr,
    output logic        a_res_valid,
    output logic [7:0]  a_res_tag,
    output logic [23:0] a_res_ycbcr,
    output logic        b_res_valid,
    output logic [23:0] b_res_ycbcr,
    output logic [7:0]  forced_cnt
);

    localparam logic [0:0] c_prio_b       = 1'b0;
    localparam logic [0:0] c_force_a      = 1'b1;
    localparam logic [7:0] c_starve_limit = 8'(STARVE_LIMIT);
    localparam logic       c_src_a        = 1'b1;
    localparam logic       c_src_b        = 1'b0;

    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic [7:0] r_wait;
    logic [7:0] w_wait_inc;
    logic       w_a_xfer;
    logic       w_b_xfer;
    logic       w_a_stall;
    logic [7:0] r_forced_cnt;
    logic       w_force_entry;

    // Pipeline stage layout: {valid, src, tag}
    logic [9:0] r_stage [0:LATENCY];
    logic [9:0] w_stage0_next;

    assign w_a_xfer   = a_valid & a_ready;
    assign w_b_xfer   = b_valid & b_ready;
    assign w_a_stall  = a_valid & ~a_ready;
    assign w_wait_inc = (r_wait == 8'hFF) ? 8'hFF : r_wait + 8'd1;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_prio_b;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_prio_b: begin
                if (w_a_stall && (w_wait_inc == c_starve_limit)) begin
                    w_state_next = c_force_a;
                end
            end
            c_force_a: begin
                w_state_next = c_prio_b;
            end
            default: begin
                w_state_next = c_prio_b;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (never depend on a_valid)
    // ------------------------------------------------------------------
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (r_state)
            c_prio_b: begin
                b_ready = 1'b1;
                a_ready = ~b_valid;
            end
            c_force_a: begin
                b_ready = 1'b0;
                a_ready = 1'b1;
            end
            default: begin
                b_ready = 1'b1;
                a_ready = ~b_valid;
            end
        endcase
    end

    assign w_force_entry = (r_state == c_prio_b) && (w_state_next == c_force_a);

    // ------------------------------------------------------------------
    // Starvation wait counter and forced-grant statistic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= 8'd0;
        end else if (!a_valid || w_a_xfer) begin
            r_wait <= 8'd0;
        end else if (w_a_stall) begin
            r_wait <= w_wait_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_forced_cnt <= 8'd0;
        end else if (w_force_entry && (r_forced_cnt != 8'hFF)) begin
            r_forced_cnt <= r_forced_cnt + 8'd1;
        end
    end

    assign forced_cnt = r_forced_cnt;

    // ------------------------------------------------------------------
    // Converter input register: loads only on a transfer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_rgb <= 24'd0;
        end else if (w_a_xfer) begin
            conv_rgb <= a_rgb;
        end else if (w_b_xfer) begin
            conv_rgb <= b_rgb;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline, aligned with the converter latency
    // ------------------------------------------------------------------
    always_comb begin
        w_stage0_next = 10'd0;
        if (w_a_xfer) begin
            w_stage0_next = {1'b1, c_src_a, a_tag};
        end else if (w_b_xfer) begin
            w_stage0_next = {1'b1, c_src_b, 8'd0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage[0] <= 10'd0;
        end else begin
            r_stage[0] <= w_stage0_next;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= LATENCY; gi++) begin : g_stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_stage[gi] <= 10'd0;
                end else begin
                    r_stage[gi] <= r_stage[gi-1];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Result capture and routing
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_res_valid <= 1'b0;
            a_res_tag   <= 8'd0;
            a_res_ycbcr <= 24'd0;
            b_res_valid <= 1'b0;
            b_res_ycbcr <= 24'd0;
        end else begin
            a_res_valid <= 1'b0;
            b_res_valid <= 1'b0;
            if (r_stage[LATENCY][9]) begin
                if (r_stage[LATENCY][8] == c_src_a) begin
                    a_res_valid <= 1'b1;
                    a_res_tag   <= r_stage[LATENCY][7:0];
                    a_res_ycbcr <= conv_ycbcr;
                end else begin
                    b_res_valid <= 1'b1;
                    b_res_ycbcr <= conv_ycbcr;
                end
            end
        end
    end

endmodule
`default_nettype wire
